shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the processor ALU path. Performs SLL, SRL or SRA on a 32-bit operand by a 5-bit shift amount.
- Each cycle applies one fixed power-of-two shift stage (16, 8, 4, 2, 1), largest first. Zero bits of the shift amount are skipped.
- The execute stage issues a request with a start/ready handshake and receives a one-cycle result_valid pulse.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
- start  input  1  request strobe; accepted only when ready=1
- op  input  2  00=SLL, 01=SRA, 10=SRL, 11=reserved
- operand  input  32  value to shift; sampled on the accepting edge
- shamt  input  5  shift amount; sampled on the accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high in SHIFT and DONE
- result  output  32  final shifted value; held until the next accepted start
- result_valid  output  1  one-cycle pulse in DONE
- exception  output  1  set with result_valid when op=11; held with result

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE.
  - result=0, result_valid=0, exception=0, busy=0, ready=1.
  - Internal work register and remaining-amount register cleared.
  - Reset overrides start on the same edge.
- States and transitions:
  - IDLE
    - start=1: latch operand into work, shamt into rem, op into mode.
    - If op=11 or shamt=0, go to DONE; otherwise go to SHIFT.
  - SHIFT
    - Each edge: k = index of highest set bit of rem.
    - work <= stage(work, 2^k, mode); clear rem[k].
    - If rem becomes 0, go to DONE.
  - DONE
    - result <= work; exception <= (mode==11); result_valid=1 for exactly this cycle.
    - Next edge: go to IDLE.
- Latency: edge accepting start to the cycle with result_valid = popcount(shamt)+1 cycles.
  - Minimum 1 (shamt=0 or op=11); maximum 6 (shamt=31).
- Stage arithmetic:
  - SLL fills vacated LSBs with 0.
  - SRL fills vacated MSBs with 0.
  - SRA fills vacated MSBs with bit 31 of the current work value. The sign is preserved across stages because each stage replicates work[31].
- op=11: result = operand unchanged, exception=1.
- result and exception hold their DONE values through IDLE until the next DONE.
- start while busy=1 is ignored; no queueing, no effect on the operation in flight.
- start asserted in the DONE cycle is ignored; the requester must wait for ready.
- Inputs operand/shamt/op may change freely after the accepting edge.
- Reset mid-operation aborts immediately. No result_valid is produced for the aborted request.

Decomposition:
- Shared include file holds:
  - op encodings: SHIFT_OP_SLL=2'b00, SHIFT_OP_SRA=2'b01, SHIFT_OP_SRL=2'b10, SHIFT_OP_RSVD=2'b11.
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE (2 bits).
- One natural sub-module: shift_stage (combinational).
  - Inputs: 32-bit value, 5-bit one-hot amount, 2-bit mode. Output: 32-bit value.
  - Implemented as five fixed-amount shift paths muxed by the one-hot amount.
  - Instantiated once in the sequencer.
- Highest-set-bit priority encoder lives inline in shift_sequencer.

Test Plan:
1. SRA, operand=0x80000000, shamt=16 -> result=0xFFFF8000, result_valid 2 cycles after the accepting edge, exception=0.
2. SLL, operand=0x00000001, shamt=31 -> result=0x80000000, result_valid 6 cycles after accept; busy high for all 6 cycles.
3. SRL, operand=0xF0000000, shamt=4 -> result=0x0F000000. Then SRA on the same operand and shamt -> result=0xFF000000.
4. Any op with shamt=0, operand=0x12345678 -> result=0x12345678 after 1 cycle. op=11 with operand=0xDEADBEEF, shamt=7 -> result=0xDEADBEEF, exception=1, latency 1.
5. Start SLL 0x1 by 31, then pulse start with different data on each busy cycle -> extra starts ignored; only result=0x80000000 is produced, exactly one result_valid pulse.
6. Start SRA 0x80000000 by 31; drive reset=0 on the 3rd busy cycle -> next cycle shows ready=1, busy=0, result=0, no result_valid. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_sequencer_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SHIFT_OP_SLL  = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRA  = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRL  = 2'b10;
    localparam logic [1:0] SHIFT_OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// One shift step: five fixed power-of-two shift paths selected by a one-hot amount.
module shift_stage
    import shift_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0]   value_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic [1:0]         mode_i,
    output logic [WIDTH-1:0]   value_o
);

    always_comb begin
        value_o = value_i;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (amt_i[k]) begin
                case (mode_i)
                    SHIFT_OP_SLL: value_o = value_i << (1 << k);
                    SHIFT_OP_SRA: value_o = $unsigned($signed(value_i) >>> (1 << k));
                    SHIFT_OP_SRL: value_o = value_i >> (1 << k);
                    default:      value_o = value_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shift unit applying one power-of-two stage per cycle, largest set bit of the amount first.
// state    | meaning
// ST_IDLE  | ready for a request; result/exception hold last values
// ST_SHIFT | one stage per edge until the remaining amount is zero
// ST_DONE  | result_valid pulse; result published from work register
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic [WIDTH-1:0]   result,
    output logic               result_valid,
    output logic               exception
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     work_q, result_q, stage_out;
    logic [SHAMT_W-1:0]   rem_q, rem_d, onehot;
    logic [1:0]           mode_q;
    logic                 exc_q;
    logic [2:0]           hi_idx;

    always_comb begin
        hi_idx = 3'd0;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (rem_q[k]) hi_idx = 3'(k);
        end
        onehot = SHAMT_W'(1) << hi_idx;
        rem_d  = rem_q & ~onehot;
    end

    shift_stage u_stage (
        .value_i (work_q),
        .amt_i   (onehot),
        .mode_i  (mode_q),
        .value_o (stage_out)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op == SHIFT_OP_RSVD || shamt == '0) state_d = ST_DONE;
                    else                                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: if (rem_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            work_q   <= '0;
            rem_q    <= '0;
            mode_q   <= SHIFT_OP_SLL;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q <= operand;
                        rem_q  <= shamt;
                        mode_q <= op;
                    end
                end
                ST_SHIFT: begin
                    work_q <= stage_out;
                    rem_q  <= rem_d;
                end
                ST_DONE: begin
                    result_q <= work_q;
                    exc_q    <= (mode_q == SHIFT_OP_RSVD);
                end
                default: ;
            endcase
        end
    end

    // In DONE the result is driven straight from work so it is valid alongside the pulse.
    always_comb begin
        ready        = (state_q == ST_IDLE);
        busy         = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        result_valid = (state_q == ST_DONE);
        result       = (state_q == ST_DONE) ? work_q : result_q;
        exception    = (state_q == ST_DONE) ? (mode_q == SHIFT_OP_RSVD) : exc_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random requests against an arithmetic model.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [4:0]  shamt = '0;
    logic        ready, busy, result_valid, exception;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    shift_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .operand      (operand),
        .shamt        (shamt),
        .ready        (ready),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            2'b00:   return a << s;
            2'b01:   return $unsigned(sa >>> s);
            2'b10:   return a >> s;
            default: return a;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [4:0] s);
        if (o == 2'b11) return 1;
        return $countones(s) + 1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request and follows it to completion; noisy pulses start with junk on busy cycles.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [4:0] s, input bit noisy);
        logic [31:0] exp_r;
        int          exp_l, lat, pulses;
        exp_r  = model_res(o, a, s);
        exp_l  = model_lat(o, s);
        lat    = -1;
        pulses = 0;
        chk({tag, ".ready_before"}, {31'd0, ready}, 32'd1);
        start = 1'b1; op = o; operand = a; shamt = s;
        tick();
        start = 1'b0;
        op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc;
                    chk({tag, ".result"}, result, exp_r);
                    chk({tag, ".exception"}, {31'd0, exception}, {31'd0, (o == 2'b11)});
                end
            end
            if (cyc <= exp_l) chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            start = noisy && busy;
            if (start) begin
                op = 2'($urandom); operand = $urandom; shamt = 5'($urandom);
            end
            tick();
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, exp_l);
        chk({tag, ".pulses"}, pulses, 32'd1);
        chk({tag, ".result_held"}, result, exp_r);
        chk({tag, ".exc_held"}, {31'd0, exception}, {31'd0, (o == 2'b11)});
        chk({tag, ".ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("reset.ready", {31'd0, ready}, 32'd1);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.valid", {31'd0, result_valid}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.exception", {31'd0, exception}, 32'd0);
        reset = 1'b1;
        tick();

        // Directed cases with spec-fixed expectations cross-checking the model.
        chk("model.sra16", model_res(2'b01, 32'h8000_0000, 5'd16), 32'hFFFF_8000);
        chk("model.srl4", model_res(2'b10, 32'hF000_0000, 5'd4), 32'h0F00_0000);
        run_op("sra16", 2'b01, 32'h8000_0000, 5'd16, 1'b0);
        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 1'b0);
        chk("sll31.value", result, 32'h8000_0000);
        run_op("srl4", 2'b10, 32'hF000_0000, 5'd4, 1'b0);
        run_op("sra4", 2'b01, 32'hF000_0000, 5'd4, 1'b0);
        chk("sra4.value", result, 32'hFF00_0000);
        for (int o = 0; o < 3; o++) run_op("shamt0", 2'(o), 32'h1234_5678, 5'd0, 1'b0);
        run_op("rsvd", 2'b11, 32'hDEAD_BEEF, 5'd7, 1'b0);
        chk("rsvd.value", result, 32'hDEAD_BEEF);
        run_op("noisy", 2'b00, 32'h0000_0001, 5'd31, 1'b1);
        chk("noisy.value", result, 32'h8000_0000);

        // Abort on the third busy cycle.
        start = 1'b1; op = 2'b01; operand = 32'h8000_0000; shamt = 5'd31;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("abort.busy3", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort.ready", {31'd0, ready}, 32'd1);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.valid", {31'd0, result_valid}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                if (result_valid) seen++;
                tick();
            end
            chk("abort.no_pulse", seen, 32'd0);
        end
        run_op("after_abort", 2'b00, 32'h0000_00F0, 5'd3, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 2'($urandom), $urandom, 5'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
